// File: rtl/char_frame_buf_pkg.sv
// -----------------------------------------------------------------------------
// char_frame_buf_pkg
// Shared constants for the character frame buffer feeding emb_layer, plus the
// character legality helper used by the optional range check.
//   N         frame length in characters
//   CHAR_LEN  bits per character code
//   PAD_CHAR  code written into slots after the sentence ends
//   CHAR_MAX  highest legal code (legal range is 1..CHAR_MAX)
//   UNK_CHAR  substitute code for illegal characters
// -----------------------------------------------------------------------------
package char_frame_buf_pkg;

    localparam int N        = 10;
    localparam int CHAR_LEN = 8;
    localparam int CNT_W    = $clog2(N);

    localparam logic [CHAR_LEN-1:0] PAD_CHAR = 8'd0;
    localparam logic [CHAR_LEN-1:0] CHAR_MAX = 8'd200;
    localparam logic [CHAR_LEN-1:0] UNK_CHAR = 8'd1;

    // Code 0 is reserved for padding, so it is never a legal sentence character.
    function automatic logic char_is_illegal(input logic [CHAR_LEN-1:0] c);
        return (c == {CHAR_LEN{1'b0}}) || (c > CHAR_MAX);
    endfunction

endpackage

// File: rtl/char_frame_buf_sanitize.sv
// -----------------------------------------------------------------------------
// char_sanitize
// Combinational range check: replaces an illegal character code with UNK_CHAR
// and flags it.
//   char_in   raw character code
//   char_out  code to store (UNK_CHAR when illegal)
//   illegal   1 when char_in is 0 or above CHAR_MAX
// -----------------------------------------------------------------------------
module char_sanitize
    import char_frame_buf_pkg::*;
(
    input  logic [CHAR_LEN-1:0] char_in,
    output logic [CHAR_LEN-1:0] char_out,
    output logic                illegal
);

    // Range check and substitution.
    always_comb begin
        illegal = char_is_illegal(char_in);
        if (illegal) begin
            char_out = UNK_CHAR;
        end else begin
            char_out = char_in;
        end
    end

endmodule

// File: rtl/char_frame_buf.sv
// -----------------------------------------------------------------------------
// char_frame_buf
// Collects character codes (one per valid/ready beat) into an N-slot frame,
// pads short sentences with PAD_CHAR, pulses run for one cycle and holds the
// packed frame on d until emb_layer answers with emb_valid.
// Optional feature: define CHAR_RANGE_CHK_EN to substitute illegal codes with
// UNK_CHAR and raise the sticky err flag.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     source presents in_char / in_last
//   in_char      character code
//   in_last      final character of the sentence
//   in_ready     beat accepted this cycle (FILL only)
//   run          one-cycle start pulse to emb_layer
//   d            packed frame, slot i at d[i*CHAR_LEN +: CHAR_LEN]
//   emb_valid    emb_layer has consumed the frame
//   busy         frame being padded, launched or embedded
//   err          sticky illegal-character flag (0 without CHAR_RANGE_CHK_EN)
// -----------------------------------------------------------------------------
module char_frame_buf
    import char_frame_buf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [CHAR_LEN-1:0]   in_char,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  run,
    output logic [N*CHAR_LEN-1:0] d,
    input  logic                  emb_valid,
    output logic                  busy,
    output logic                  err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_PAD  = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [2:0]          state_r;
    logic [2:0]          state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                wr_en_s;
    logic [CHAR_LEN-1:0] wr_char_s;
    logic [CHAR_LEN-1:0] store_char_s;

`ifdef CHAR_RANGE_CHK_EN
    logic illegal_s;
    logic err_r;

    char_sanitize u_sanitize (
        .char_in  (in_char),
        .char_out (store_char_s),
        .illegal  (illegal_s)
    );

    // Sticky error: any accepted illegal character latches err until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (in_valid && (state_r == ST_FILL) && illegal_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign store_char_s = in_char;
    assign err          = 1'b0;
`endif

    // Next-state, slot counter and slot write decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        wr_en_s     = 1'b0;
        wr_char_s   = store_char_s;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_FILL;
                cnt_nxt_s   = CNT_ZERO;
            end
            ST_FILL: begin
                if (in_valid) begin
                    wr_en_s = 1'b1;
                    // A full frame launches regardless of in_last.
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                        if (in_last) begin
                            state_nxt_s = ST_PAD;
                        end else begin
                            state_nxt_s = ST_FILL;
                        end
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_PAD: begin
                wr_en_s   = 1'b1;
                wr_char_s = PAD_CHAR;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (emb_valid) begin
                    state_nxt_s = ST_FILL;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and slot counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Frame storage: one slot written per beat or pad cycle, never cleared between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            d <= {(N*CHAR_LEN){1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en_s && (cnt_r == CNT_W'(i))) begin
                    d[i*CHAR_LEN +: CHAR_LEN] <= wr_char_s;
                end
            end
        end
    end

    assign in_ready = (state_r == ST_FILL);
    assign run      = (state_r == ST_RUN);
    assign busy     = (state_r != ST_IDLE) && (state_r != ST_FILL);

endmodule

// File: tb/tb_char_frame_buf.sv
module tb_char_frame_buf;

    localparam int  N   = 10;
    localparam time TCK = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_last;
    logic        in_ready;
    logic        run;
    logic [79:0] d;
    logic        emb_valid;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    char_frame_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .run       (run),
        .d         (d),
        .emb_valid (emb_valid),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic [79:0] d;
        time         t;
        logic        err;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] frame_data [N];
    logic       model_err = 1'b0;
    logic       prev_run  = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what a character becomes once stored.
    function automatic logic [7:0] ref_store(input logic [7:0] c);
`ifdef CHAR_RANGE_CHK_EN
        if (c == 8'd0 || c > 8'd200) return 8'd1;
`endif
        return c;
    endfunction

    function automatic logic ref_illegal(input logic [7:0] c);
`ifdef CHAR_RANGE_CHK_EN
        return (c == 8'd0 || c > 8'd200);
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: every run pulse is matched against the oldest expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (run) begin
            chk("run_single_cycle", {79'd0, prev_run}, 80'd0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_run: got run=1 expected no run");
            end else begin
                e = sb_q.pop_front();
                chk("frame_d", d, e.d);
                chk("run_time", 80'($time), 80'(e.t));
                chk("err_at_run", {79'd0, err}, {79'd0, e.err});
            end
        end
        prev_run = run;
    end

    // Drives frame_data[0..len-1]; pushes the expected frame on the last beat.
    task automatic send_frame(input int len, input bit last_on_full, input bit push_exp, input bit gaps);
        logic [79:0] e;
        exp_t        x;
        int          guard;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk("err_live", {79'd0, err}, {79'd0, model_err});
            guard = 0;
            while ((!in_ready || (gaps && $urandom_range(0, 3) == 0)) && guard < 50) begin
                in_valid  = 1'b0;
                in_char   = 8'($urandom);
                emb_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                guard++;
            end
            chk("in_ready_beat", {79'd0, in_ready}, 80'd1);
            in_valid  = 1'b1;
            in_char   = frame_data[i];
            in_last   = (i == len - 1) && (len < N || last_on_full);
            emb_valid = 1'($urandom_range(0, 1));
            model_err = model_err | ref_illegal(frame_data[i]);
            if (i == len - 1 && push_exp) begin
                e = '0;
                for (int s = 0; s < N; s++) begin
                    e[s*8 +: 8] = (s < len) ? ref_store(frame_data[s]) : 8'h00;
                end
                x.d   = e;
                x.t   = $time + (1 + (N - len)) * TCK;
                x.err = model_err;
                sb_q.push_back(x);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_char   = 8'($urandom);
        emb_valid = 1'b0;
        chk("err_live", {79'd0, err}, {79'd0, model_err});
    endtask

    task automatic wait_run();
        int g = 0;
        while (!run && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("run_seen", {79'd0, run}, 80'd1);
    endtask

    task automatic release_frame(input int hold);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        emb_valid = 1'b1;
        @(negedge clk);
        emb_valid = 1'b0;
    endtask

    task automatic seq_frame();
        for (int i = 0; i < N; i++) frame_data[i] = 8'(i + 1);
    endtask

    initial begin
        logic [79:0] held;
        logic [7:0]  exp_s2;
        rst = 1'b1; in_valid = 1'b0; in_char = 8'd0; in_last = 1'b0; emb_valid = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {79'd0, in_ready}, 80'd0);
        chk("rst_run", {79'd0, run}, 80'd0);
        chk("rst_busy", {79'd0, busy}, 80'd0);
        chk("rst_d", d, 80'd0);
        chk("rst_err", {79'd0, err}, 80'd0);
        rst = 1'b0; emb_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_idle", {79'd0, in_ready}, 80'd1);

        // Test 1: 1..10 back-to-back
        seq_frame();
        send_frame(10, 1'b0, 1'b1, 1'b0);
        chk("t1_run", {79'd0, run}, 80'd1);
        chk("t1_ready_low", {79'd0, in_ready}, 80'd0);
        chk("t1_d", d, 80'h0A090807060504030201);
        release_frame(0);

        // Test 2 + 3: short frame, then hold WAIT for 20 cycles
        frame_data[0] = 8'd5; frame_data[1] = 8'd6; frame_data[2] = 8'd7;
        send_frame(3, 1'b0, 1'b1, 1'b0);
        wait_run();
        chk("t2_d", d, 80'h00000000000000070605);
        held = d;
        repeat (20) begin
            @(negedge clk);
            chk("t3_d_stable", d, held);
            chk("t3_ready", {79'd0, in_ready}, 80'd0);
            chk("t3_busy", {79'd0, busy}, 80'd1);
            chk("t3_no_run", {79'd0, run}, 80'd0);
        end
        emb_valid = 1'b1;
        @(negedge clk);
        emb_valid = 1'b0;
        chk("t3_ready_back", {79'd0, in_ready}, 80'd1);
        chk("t3_busy_low", {79'd0, busy}, 80'd0);

        // Test 4: in_last on the 10th beat (no padding; timing checked by monitor)
        for (int i = 0; i < N; i++) frame_data[i] = 8'($urandom_range(1, 200));
        send_frame(10, 1'b1, 1'b1, 1'b0);
        wait_run();
        release_frame(2);

        // Test 5: reset during PAD aborts the frame
        frame_data[0] = 8'd9; frame_data[1] = 8'd8; frame_data[2] = 8'd7;
        send_frame(3, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_err = 1'b0;
        chk("t5_ready_rst", {79'd0, in_ready}, 80'd0);
        chk("t5_busy_rst", {79'd0, busy}, 80'd0);
        chk("t5_run_rst", {79'd0, run}, 80'd0);
        chk("t5_d_rst", d, 80'd0);
        @(negedge clk);
        chk("t5_ready_fill", {79'd0, in_ready}, 80'd1);
        seq_frame();
        send_frame(10, 1'b0, 1'b1, 1'b0);
        chk("t5_run", {79'd0, run}, 80'd1);
        chk("t5_d", d, 80'h0A090807060504030201);
        release_frame(1);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, N);
            for (int i = 0; i < N; i++) frame_data[i] = 8'($urandom);
            send_frame(len, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            wait_run();
            release_frame($urandom_range(0, 4));
        end

        // Test 6: illegal char 250 at slot 2 after a clean reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) frame_data[i] = 8'($urandom_range(1, 200));
        frame_data[2] = 8'd250;
        send_frame(10, 1'b0, 1'b1, 1'b0);
        wait_run();
`ifdef CHAR_RANGE_CHK_EN
        exp_s2 = 8'h01;
`else
        exp_s2 = 8'hFA;
`endif
        chk("t6_slot2", {72'd0, d[23:16]}, {72'd0, exp_s2});
        release_frame(0);
        for (int i = 0; i < N; i++) frame_data[i] = 8'($urandom_range(1, 200));
        send_frame(4, 1'b0, 1'b1, 1'b0);
        wait_run();
        chk("t6_err_sticky", {79'd0, err}, {79'd0, model_err});
        release_frame(0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 80'(sb_q.size()), 80'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(500000);
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
